// File: rtl/intersection_phase_controller.sv
// ---------------------------------------------------------------------------
// intersection_phase_controller
//
// Sequences NUM_APPROACHES approaches (2..4) through a fixed rotation:
//   ALL_RED -> [LEFT] -> GREEN -> YELLOW -> ALL_RED (next approach)
// A fault request (in_issue) overrides the rotation with a flash pattern:
// even approaches flash yellow, odd approaches flash red.  Pedestrian
// buttons are latched per approach and turn into a walk interval at the
// start of that approach's next green.
//
// Ports
//   in_clock              rising-edge clock for all state
//   in_reset_n            synchronous, active-low reset
//   in_issue              high selects flash mode (beats the rotation)
//   in_ped_request[N]     pedestrian buttons, single-cycle pulse is enough
//   in_left_enable[N]     protected-left enable, sampled at ALL_RED exit
//   out_red_light[N]      red lamp per approach
//   out_green_light[N]    green lamp per approach
//   out_yellow_light[N]   yellow lamp per approach
//   out_left_turn_light[N] left-turn arrow per approach
//   out_pedestrian_light[N] walk signal per approach
//   out_active[2]         index of the approach owning the current phase
//   out_state[3]          0 ALL_RED, 1 LEFT, 2 GREEN, 3 YELLOW, 4 FLASH
//   counter[CNT_W]        cycles spent in the current state, 0 on entry
//
// Every output is a flop.  The lamp decode is evaluated on the *next*
// state/counter values so lamps, out_state and counter all change on the
// same edge with no input-to-output combinational path.
// ---------------------------------------------------------------------------
module intersection_phase_controller #(
    parameter int NUM_APPROACHES    = 2,
    parameter int ALL_RED_CYCLES    = 50,
    parameter int LEFT_TURN_CYCLES  = 300,
    parameter int GREEN_CYCLES      = 1000,
    parameter int YELLOW_CYCLES     = 200,
    parameter int PED_CYCLES        = 400,
    parameter int FLASH_HALF_CYCLES = 100,
    parameter int CNT_W             = 32
) (
    input  logic                      in_clock,
    input  logic                      in_reset_n,
    input  logic                      in_issue,
    input  logic [NUM_APPROACHES-1:0] in_ped_request,
    input  logic [NUM_APPROACHES-1:0] in_left_enable,
    output logic [NUM_APPROACHES-1:0] out_red_light,
    output logic [NUM_APPROACHES-1:0] out_green_light,
    output logic [NUM_APPROACHES-1:0] out_yellow_light,
    output logic [NUM_APPROACHES-1:0] out_left_turn_light,
    output logic [NUM_APPROACHES-1:0] out_pedestrian_light,
    output logic [1:0]                out_active,
    output logic [2:0]                out_state,
    output logic [CNT_W-1:0]          counter
);

    localparam int N = NUM_APPROACHES;

    // Last counter value of each timed state (state exits when counter hits it).
    localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEFT_LAST    = CNT_W'(LEFT_TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(2 * FLASH_HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_HALF   = CNT_W'(FLASH_HALF_CYCLES);
    localparam logic [CNT_W-1:0] PED_LEN      = CNT_W'(PED_CYCLES);
    localparam logic [1:0]       LAST_IDX     = 2'(N - 1);

    typedef enum logic [2:0] {
        ST_ALL_RED = 3'd0,
        ST_LEFT    = 3'd1,
        ST_GREEN   = 3'd2,
        ST_YELLOW  = 3'd3,
        ST_FLASH   = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // Registers and their next-state values
    // ---------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [1:0]       active_q,  active_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [N-1:0]     latch_q,   latch_d;
    logic             walk_q,    walk_d;

    logic [N-1:0]     red_q,    red_d;
    logic [N-1:0]     green_q,  green_d;
    logic [N-1:0]     yellow_q, yellow_d;
    logic [N-1:0]     left_q,   left_d;
    logic [N-1:0]     ped_q,    ped_d;

    // One-hot views of the active index.  Selecting through a mask keeps
    // the 2-bit index from ever addressing past N-1 when N < 4.
    logic [N-1:0]     act_sel_q;
    logic [N-1:0]     act_sel_d;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign act_sel_q[gi] = (active_q == 2'(gi));
            assign act_sel_d[gi] = (active_d == 2'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------
    // Process 1: state register (also holds the registered lamp outputs)
    // ---------------------------------------------------------------
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state_q   <= ST_ALL_RED;
            active_q  <= 2'd0;
            counter_q <= '0;
            latch_q   <= '0;
            walk_q    <= 1'b0;
            red_q     <= '1;
            green_q   <= '0;
            yellow_q  <= '0;
            left_q    <= '0;
            ped_q     <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            counter_q <= counter_d;
            latch_q   <= latch_d;
            walk_q    <= walk_d;
            red_q     <= red_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            left_q    <= left_d;
            ped_q     <= ped_d;
        end
    end

    // ---------------------------------------------------------------
    // Process 2: next-state logic
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] dur_last;
    logic             phase_done;
    logic             left_sel;
    logic [N-1:0]     req_latched;

    always_comb begin
        dur_last = FLASH_LAST;
        case (state_q)
            ST_ALL_RED: dur_last = ALL_RED_LAST;
            ST_LEFT:    dur_last = LEFT_LAST;
            ST_GREEN:   dur_last = GREEN_LAST;
            ST_YELLOW:  dur_last = YELLOW_LAST;
            default:    dur_last = FLASH_LAST;
        endcase
    end

    assign phase_done = (counter_q == dur_last);
    assign left_sel   = |(in_left_enable & act_sel_q);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        counter_d   = counter_q + CNT_W'(1);
        latch_d     = latch_q;
        walk_d      = walk_q;
        req_latched = latch_q | in_ped_request;

        if (state_q == ST_FLASH) begin
            // Requests are ignored while flashing; latches stay clear.
            latch_d = '0;
            if (!in_issue) begin
                state_d   = ST_ALL_RED;
                active_d  = 2'd0;
                counter_d = '0;
            end else if (counter_q == FLASH_LAST) begin
                counter_d = '0;
            end
        end else if (in_issue) begin
            state_d   = ST_FLASH;
            counter_d = '0;
            latch_d   = '0;
            walk_d    = 1'b0;
        end else begin
            latch_d = req_latched;
            if (phase_done) begin
                counter_d = '0;
                case (state_q)
                    ST_ALL_RED: state_d = left_sel ? ST_LEFT : ST_GREEN;
                    ST_LEFT:    state_d = ST_GREEN;
                    ST_GREEN:   state_d = ST_YELLOW;
                    ST_YELLOW: begin
                        state_d  = ST_ALL_RED;
                        active_d = (active_q == LAST_IDX) ? 2'd0 : active_q + 2'd1;
                    end
                    default:    state_d = ST_ALL_RED;
                endcase
                // Green entry: a request on this very edge counts, and the
                // latch is consumed.  Later requests in this green re-latch
                // for the approach's next green.
                if (state_d == ST_GREEN) begin
                    walk_d  = |(req_latched & act_sel_q);
                    latch_d = req_latched & ~act_sel_q;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Process 3: output decode from next-state values
    // ---------------------------------------------------------------
    logic flash_d;
    logic flash_on_d;
    logic walk_win_d;

    always_comb begin
        flash_d    = (state_d == ST_FLASH);
        flash_on_d = (counter_d < FLASH_HALF);
        walk_win_d = walk_d && (state_d == ST_GREEN) && (counter_d < PED_LEN);
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lamp
            localparam bit IS_ODD = ((gi % 2) == 1);
            // Non-active approaches and clearance/left phases show red.
            assign red_d[gi]    = flash_d ? (flash_on_d && IS_ODD)
                                          : (!act_sel_d[gi] ||
                                             state_d == ST_ALL_RED ||
                                             state_d == ST_LEFT);
            assign green_d[gi]  = !flash_d && act_sel_d[gi] && (state_d == ST_GREEN);
            assign yellow_d[gi] = flash_d ? (flash_on_d && !IS_ODD)
                                          : (act_sel_d[gi] && state_d == ST_YELLOW);
            assign left_d[gi]   = !flash_d && act_sel_d[gi] && (state_d == ST_LEFT);
            assign ped_d[gi]    = act_sel_d[gi] && walk_win_d;
        end
    endgenerate

    assign out_red_light        = red_q;
    assign out_green_light      = green_q;
    assign out_yellow_light     = yellow_q;
    assign out_left_turn_light  = left_q;
    assign out_pedestrian_light = ped_q;
    assign out_active           = active_q;
    assign out_state            = state_q;
    assign counter              = counter_q;

endmodule

// File: tb/tb_intersection_phase_controller.sv
// ---------------------------------------------------------------------------
// Bench for intersection_phase_controller.
// Main instance: N=3, ALL_RED=2, LEFT=4, GREEN=8, YELLOW=3, PED=5, FLASH_HALF=2.
// Two extra instances (N=2, N=4) run the plain rotation with idle inputs and
// are checked against a closed-form position-in-rotation formula.
// ---------------------------------------------------------------------------
module tb_intersection_phase_controller;

    localparam int N  = 3;
    localparam int AR = 2;
    localparam int LT = 4;
    localparam int GR = 8;
    localparam int YE = 3;
    localparam int PD = 5;
    localparam int FH = 2;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, rst_s_n, issue;
    logic [N-1:0]  ped, left;
    logic [N-1:0]  red, green, yellow, larrow, pedl;
    logic [1:0]    active;
    logic [2:0]    state;
    logic [CW-1:0] cnt;

    intersection_phase_controller #(
        .NUM_APPROACHES(N), .ALL_RED_CYCLES(AR), .LEFT_TURN_CYCLES(LT),
        .GREEN_CYCLES(GR), .YELLOW_CYCLES(YE), .PED_CYCLES(PD),
        .FLASH_HALF_CYCLES(FH), .CNT_W(CW)
    ) dut (
        .in_clock(clk), .in_reset_n(rst_n), .in_issue(issue),
        .in_ped_request(ped), .in_left_enable(left),
        .out_red_light(red), .out_green_light(green), .out_yellow_light(yellow),
        .out_left_turn_light(larrow), .out_pedestrian_light(pedl),
        .out_active(active), .out_state(state), .counter(cnt)
    );

    // Sweep instances with idle inputs
    logic          zero1 = 1'b0;
    logic [1:0]    zero2 = '0;
    logic [3:0]    zero4 = '0;
    logic [1:0]    r2, g2, y2, l2, p2, a2;
    logic [2:0]    s2;
    logic [CW-1:0] c2;
    logic [3:0]    r4, g4, y4, l4, p4;
    logic [1:0]    a4;
    logic [2:0]    s4;
    logic [CW-1:0] c4;

    intersection_phase_controller #(
        .NUM_APPROACHES(2), .ALL_RED_CYCLES(AR), .LEFT_TURN_CYCLES(LT),
        .GREEN_CYCLES(GR), .YELLOW_CYCLES(YE), .PED_CYCLES(PD),
        .FLASH_HALF_CYCLES(FH), .CNT_W(CW)
    ) dut2 (
        .in_clock(clk), .in_reset_n(rst_s_n), .in_issue(zero1),
        .in_ped_request(zero2), .in_left_enable(zero2),
        .out_red_light(r2), .out_green_light(g2), .out_yellow_light(y2),
        .out_left_turn_light(l2), .out_pedestrian_light(p2),
        .out_active(a2), .out_state(s2), .counter(c2)
    );

    intersection_phase_controller #(
        .NUM_APPROACHES(4), .ALL_RED_CYCLES(AR), .LEFT_TURN_CYCLES(LT),
        .GREEN_CYCLES(GR), .YELLOW_CYCLES(YE), .PED_CYCLES(PD),
        .FLASH_HALF_CYCLES(FH), .CNT_W(CW)
    ) dut4 (
        .in_clock(clk), .in_reset_n(rst_s_n), .in_issue(zero1),
        .in_ped_request(zero4), .in_left_enable(zero4),
        .out_red_light(r4), .out_green_light(g4), .out_yellow_light(y4),
        .out_left_turn_light(l4), .out_pedestrian_light(p4),
        .out_active(a4), .out_state(s4), .counter(c4)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_cyc = 0;   // cycle index of main DUT since its last reset
    int m_sw  = 0;   // cycle index of sweep instances

    // ---------------- behavioural reference (main instance) ----------------
    // Phases: 0 ALL_RED, 1 LEFT, 2 GREEN, 3 YELLOW, 4 FLASH
    int           m_state, m_act, m_cnt;
    bit           m_walk;
    bit [N-1:0]   m_latch;

    function automatic int dur(input int s);
        case (s)
            0: return AR;
            1: return LT;
            2: return GR;
            default: return YE;
        endcase
    endfunction

    task automatic model_step(input logic r_n, input logic iss,
                              input logic [N-1:0] pr, input logic [N-1:0] le);
        bit [N-1:0] nl;
        if (!r_n) begin
            m_state = 0; m_act = 0; m_cnt = 0; m_latch = '0; m_walk = 0;
            return;
        end
        if (m_state == 4) begin
            if (!iss) begin
                m_state = 0; m_act = 0; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % (2 * FH);
            end
            return;
        end
        if (iss) begin
            m_state = 4; m_cnt = 0; m_latch = '0; m_walk = 0;
            return;
        end
        nl = m_latch | pr;
        if (m_cnt == dur(m_state) - 1) begin
            m_cnt = 0;
            case (m_state)
                0: m_state = le[m_act] ? 1 : 2;
                1: m_state = 2;
                2: m_state = 3;
                default: begin
                    m_state = 0;
                    m_act = (m_act + 1) % N;
                end
            endcase
            if (m_state == 2) begin
                m_walk = nl[m_act];
                nl[m_act] = 1'b0;
            end
        end else begin
            m_cnt++;
        end
        m_latch = nl;
    endtask

    function automatic logic [63:0] model_outs();
        logic [N-1:0] r, g, y, l, p;
        r = '0; g = '0; y = '0; l = '0; p = '0;
        for (int i = 0; i < N; i++) begin
            if (m_state == 4) begin
                if (m_cnt < FH) begin
                    if (i % 2 == 1) r[i] = 1'b1;
                    else            y[i] = 1'b1;
                end
            end else if (i != m_act || m_state == 0) begin
                r[i] = 1'b1;
            end else if (m_state == 1) begin
                r[i] = 1'b1; l[i] = 1'b1;
            end else if (m_state == 2) begin
                g[i] = 1'b1;
                p[i] = m_walk && (m_cnt < PD);
            end else begin
                y[i] = 1'b1;
            end
        end
        return {12'b0, r, g, y, l, p, 2'(m_act), 3'(m_state), 32'(m_cnt)};
    endfunction

    function automatic logic [63:0] dut_outs();
        return {12'b0, red, green, yellow, larrow, pedl, active, state, cnt};
    endfunction

    // Closed-form expectation for an idle rotation with no left phase.
    function automatic logic [63:0] sweep_exp(input int nn, input int m);
        int per, off, a, st, c;
        logic [3:0] r, g, y;
        per = AR + GR + YE;
        a   = (m / per) % nn;
        off = m % per;
        if (off < AR)           begin st = 0; c = off;           end
        else if (off < AR + GR) begin st = 2; c = off - AR;      end
        else                    begin st = 3; c = off - AR - GR; end
        r = '0; g = '0; y = '0;
        for (int i = 0; i < nn; i++) begin
            if (i != a || st == 0) r[i] = 1'b1;
            else if (st == 2)      g[i] = 1'b1;
            else                   y[i] = 1'b1;
        end
        return {7'b0, r, g, y, 4'b0, 4'b0, 2'(a), 3'(st), 32'(c)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s n=%0d got=%h expected=%h", tag, n_cyc, obs, exp);
        end
    endtask

    // One clock edge: advance the models with the inputs present at the
    // edge, then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step(rst_n, issue, ped, left);
        if (!rst_n)   n_cyc = 0; else n_cyc++;
        if (!rst_s_n) m_sw  = 0; else m_sw++;
        #1;
        chk("model", dut_outs(), model_outs());
        chk("sweep_n2", {7'b0, 2'b0, r2, 2'b0, g2, 2'b0, y2, 2'b0, l2, 2'b0, p2, a2, s2, c2},
            sweep_exp(2, m_sw));
        chk("sweep_n4", {7'b0, r4, g4, y4, l4, p4, a4, s4, c4}, sweep_exp(4, m_sw));
    endtask

    task automatic run_to(input int target);
        while (n_cyc < target) tick();
    endtask

    task automatic do_reset(input logic [N-1:0] le);
        rst_n = 1'b0; issue = 1'b0; ped = '0; left = le;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_s_n = 1'b0;
        do_reset('0);
        rst_s_n = 1'b1;

        // ---- reset state and basic rotation with pedestrian pulse ----
        chk("rst_state", state, 3'd0);
        chk("rst_red", red, 3'b111);
        chk("rst_cnt", cnt, 0);
        chk("rst_other", {green, yellow, larrow, pedl}, 12'd0);
        run_to(1);  chk("allred_n1", state, 3'd0);
        run_to(2);  chk("green0_n2", {state, active, green}, {3'd2, 2'd0, 3'b001});
        run_to(3);  ped = 3'b100; tick(); ped = '0;
        run_to(9);  chk("green_n9", state, 3'd2);
        run_to(10); chk("yellow_n10", {state, yellow}, {3'd3, 3'b001});
        run_to(13); chk("allred_a1", {state, active}, {3'd0, 2'd1});
        run_to(15); chk("green1_n15", green, 3'b010);
        run_to(28); chk("ped2_start", {state, active, pedl}, {3'd2, 2'd2, 3'b100});
        run_to(32); chk("ped2_last", pedl, 3'b100);
        run_to(33); chk("ped2_off", pedl, 3'b000);
        run_to(41); chk("green0_n41", {active, green, pedl}, {2'd0, 3'b001, 3'b000});
        // request on approach 2's green-entry edge is served in that green
        run_to(66); ped = 3'b100; tick(); ped = '0;
        chk("ped_entry", {state, active, pedl}, {3'd2, 2'd2, 3'b100});
        run_to(71); chk("ped_entry_last", pedl, 3'b100);
        tick();     chk("ped_entry_off", pedl, 3'b000);

        // ---- left-turn phase on approach 1 ----
        do_reset(3'b010);
        run_to(15); chk("left_n15", {state, active, red, larrow}, {3'd1, 2'd1, 3'b111, 3'b010});
        run_to(18); chk("left_n18", state, 3'd1);
        run_to(19); chk("green_after_left", {state, green, larrow}, {3'd2, 3'b010, 3'b000});
        run_to(80);

        // ---- flash mode ----
        do_reset('0);
        run_to(5); issue = 1'b1; tick();
        chk("flash_entry", {state, cnt[7:0], yellow, red, green}, {3'd4, 8'd0, 3'b101, 3'b010, 3'b000});
        run_to(8);  chk("flash_off8", {yellow, red}, 6'd0);
        run_to(9);  chk("flash_off9", {yellow, red}, 6'd0);
        run_to(10); chk("flash_on10", {yellow, red}, {3'b101, 3'b010});
        issue = 1'b0; tick();
        chk("flash_exit", {state, active, cnt[7:0], red}, {3'd0, 2'd0, 8'd0, 3'b111});

        // ---- reset mid-YELLOW with latch pending, in_issue also high ----
        do_reset('0);
        run_to(30); ped = 3'b001; tick(); ped = '0;
        run_to(37); chk("yellow_a2", {state, active}, {3'd3, 2'd2});
        rst_n = 1'b0; issue = 1'b1; tick();
        chk("reset_wins", {state, active, cnt[7:0], red}, {3'd0, 2'd0, 8'd0, 3'b111});
        rst_n = 1'b1; issue = 1'b0;
        run_to(2); chk("latch_cleared", {state, active, pedl}, {3'd2, 2'd0, 3'b000});

        // ---- randomized operation against the reference model ----
        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 99) < 3) issue = ~issue;
            for (int i = 0; i < N; i++) ped[i] = ($urandom_range(0, 7) == 0);
            left = 3'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
